// File: rtl/uart_frame_tx.sv
// Frame-to-byte serializer: captures a UART_FRAME_SIZE-byte frame and streams it LSB-byte first.
// Define UART_FRAME_TX_CSUM_EN to append an XOR checksum byte after each frame.
module uart_frame_tx #(
  parameter int DBITS           = 8,
  parameter int UART_FRAME_SIZE = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [UART_FRAME_SIZE*DBITS-1:0] frame_in,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  output logic [DBITS-1:0]                 byte_out,
  output logic                             byte_valid,
  input  logic                             byte_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun,
  output logic [7:0]                       overrun_count
);

  localparam int IW = $clog2(UART_FRAME_SIZE + 1);
  localparam int SW = (UART_FRAME_SIZE > 1) ? $clog2(UART_FRAME_SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(UART_FRAME_SIZE - 1);

`ifdef UART_FRAME_TX_CSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  logic [DBITS-1:0] csum;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t state, state_nxt;
  logic [UART_FRAME_SIZE-1:0][DBITS-1:0] shadow;
  logic [IW-1:0] idx, idx_nxt;
  logic [SW-1:0] sel;
  logic capture, drop, done_nxt;

  // idx never exceeds LAST, so the narrower select index is lossless
  assign sel  = idx[SW-1:0];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    frame_ready = 1'b0;
    byte_valid  = 1'b0;
    byte_out    = '0;
    capture     = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        byte_out   = shadow[sel];
        if (byte_ready) begin
          if (idx == LAST) begin
`ifdef UART_FRAME_TX_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
`ifdef UART_FRAME_TX_CSUM_EN
      CSUM: begin
        byte_valid = 1'b1;
        byte_out   = csum;
        if (byte_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // a frame offered while not ready (including the last-handshake cycle) is dropped
    drop = frame_valid & ~frame_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      shadow        <= '0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      idx        <= idx_nxt;
      frame_done <= done_nxt;
      overrun    <= drop;
      if (capture) shadow <= frame_in;
      if (drop && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
  end

`ifdef UART_FRAME_TX_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                           csum <= '0;
    else if (capture)                    csum <= '0;
    else if (state == SEND && byte_ready) csum <= csum ^ byte_out;
  end
`endif

endmodule
